button_debounce: RTL and testbench

Synchronises one asynchronous, bouncing input (push-button, switch, external strobe) into the `clk` domain and filters it into a clean, glitch-free level. It sits directly upstream of the clock-domain edge detectors: `db_out` drives their `I` input, so their `Q`/`out` logic only ever sees one transition per physical press or release. `busy` flags that a candidate transition is being qualified.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/button_debounce_if.sv | 12 +
 rtl/bit_sync.sv | 28 ++
 rtl/button_debounce.sv | 91 +++++++++
 tb/tb_button_debounce.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: state encodings, default
// parameter values and the counter-width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;

    // Counter width: $clog2(cycles), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : int'($clog2(cycles));
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Bundle for the debouncer: raw input in, clean level and busy flag out.
//   I      : raw asynchronous input (master drives)
//   db_out : debounced level (slave drives)
//   busy   : candidate transition being qualified (slave drives)
interface button_debounce_if;
    logic I;
    logic db_out;
    logic busy;

    modport master (output I, input db_out, input busy);
    modport slave  (input I, output db_out, output busy);
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears the chain
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Synchronises and debounces one bouncing asynchronous input into a clean level.
//   clk          : single clock, rising edge
//   reset        : asynchronous active-high reset
//   bus.I        : raw asynchronous input
//   bus.db_out   : debounced level, registered
//   bus.busy     : high while a candidate change is being qualified
module button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    button_debounce_if.slave   bus
);

    localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             db_q;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.I),
        .q     (s)
    );

    // Qualification FSM: a change is accepted after the entry cycle plus
    // DEBOUNCE_CYCLES consecutive cycles at the new level; any reversion
    // throws the candidate away with no partial credit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_STABLE_LO;
            cnt   <= '0;
            db_q  <= 1'b0;
        end else begin
            case (state)
                ST_STABLE_LO: begin
                    if (s) begin
                        state <= ST_WAIT_HI;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (!s) begin
                        state <= ST_STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_STABLE_HI;
                        db_q  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STABLE_HI: begin
                    if (!s) begin
                        state <= ST_WAIT_LO;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_LO: begin
                    if (s) begin
                        state <= ST_STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_STABLE_LO;
                        db_q  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_STABLE_LO;
                    cnt   <= '0;
                    db_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.db_out = db_q;
    assign bus.busy   = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_button_debounce;

    localparam int unsigned SS = 2;
    localparam int unsigned DC = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    button_debounce_if bus ();

    button_debounce #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the FSM sees I delayed by SS edges; the level flips once
    // DC+1 consecutive samples disagree with it; busy = a disagreement run
    // is in progress.
    logic [SS-1:0] m_pipe;
    int            m_run;
    logic          m_db;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pipe = '0;
            m_run  = 0;
            m_db   = 1'b0;
        end else begin
            if (m_pipe[SS-1] != m_db) begin
                m_run++;
                if (m_run == int'(DC) + 1) begin
                    m_db  = m_pipe[SS-1];
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_pipe = {m_pipe[SS-2:0], bus.I};
        end
    end

    // Count debounced edges as a downstream edge detector would.
    int db_rises = 0;
    int db_falls = 0;
    logic db_prev = 1'b0;
    always @(negedge clk) begin
        if (!db_prev && bus.db_out === 1'b1) db_rises++;
        if (db_prev && bus.db_out === 1'b0) db_falls++;
        db_prev = bus.db_out;
    end

    typedef struct {
        logic i;
        logic db;
        logic busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic i, input logic db, input logic busy);
        vec_t v;
        v.i = i; v.db = db; v.busy = busy;
        tbl.push_back(v);
    endtask

    initial begin
        int first_edge;
        int falls0;
        int busy_run;
        int busy_max;
        logic db_start;

        bus.I = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_db", bus.db_out, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_cnt", 32'(dut.cnt), 0);
        reset = 1'b0;

        // Clean press: busy on edge 3, db_out on edge 7.
        add(1,0,0); add(1,0,0); add(1,0,1); add(1,0,1);
        add(1,0,1); add(1,0,1); add(1,1,0); add(1,1,0);
        // Release: mirror image.
        add(0,1,0); add(0,1,0); add(0,1,1); add(0,1,1);
        add(0,1,1); add(0,1,1); add(0,0,0); add(0,0,0);
        // Short glitch: 4 high cycles never qualify.
        add(1,0,0); add(1,0,0); add(1,0,1); add(1,0,1);
        add(0,0,1); add(0,0,1); add(0,0,0); add(0,0,0);
        // Bounce 1,0,1,1,0 then steady high.
        add(1,0,0); add(0,0,0); add(1,0,1); add(1,0,0);
        add(0,0,1); add(1,0,1); add(1,0,0); add(1,0,1);
        add(1,0,1); add(1,0,1); add(1,0,1); add(1,1,0);
        // Second release.
        add(0,1,0); add(0,1,0); add(0,1,1); add(0,1,1);
        add(0,1,1); add(0,1,1); add(0,0,0); add(0,0,0);

        falls0 = db_falls;
        for (int k = 0; k < tbl.size(); k++) begin
            bus.I = tbl[k].i;
            @(negedge clk);
            check($sformatf("vec%0d_db", k), bus.db_out, tbl[k].db);
            check($sformatf("vec%0d_busy", k), bus.busy, tbl[k].busy);
        end
        check("falls_during_table", db_falls - falls0, 2);

        // Reset in the middle of a WAIT, I kept high through release.
        bus.I = 1'b1;
        repeat (5) @(negedge clk);
        check("midwait_busy", bus.busy, 1);
        check("midwait_cnt", 32'(dut.cnt), 2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_db", bus.db_out, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_cnt", 32'(dut.cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        first_edge = 0;
        for (int e = 1; e <= 20 && first_edge == 0; e++) begin
            @(negedge clk);
            if (bus.db_out === 1'b1) first_edge = e;
        end
        check("post_reset_latency", first_edge, 7);

        // Back-to-back toggles: 3 low / 3 high from db_out=1.
        db_start = bus.db_out;
        busy_run = 0;
        busy_max = 0;
        for (int c = 0; c < 40; c++) begin
            bus.I = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            busy_run = (bus.busy === 1'b1) ? busy_run + 1 : 0;
            if (busy_run > busy_max) busy_max = busy_run;
            check("toggle_model_db", bus.db_out, m_db);
            check("toggle_model_busy", bus.busy, (m_run != 0));
        end
        check("toggle_db_unchanged", bus.db_out, db_start);
        check("toggle_busy_max_le4", (busy_max <= 4), 1);

        // Random holds against the reference model.
        for (int n = 0; n < 120; n++) begin
            bus.I = 1'($urandom_range(0, 1));
            for (int h = 0; h < int'($urandom_range(1, 8)); h++) begin
                @(negedge clk);
                check("rand_db", bus.db_out, m_db);
                check("rand_busy", bus.busy, (m_run != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
